// File: rtl/cc_decoder_strobe.sv
// rtl/cc_decoder_strobe.sv - registered active-low one-hot write strobe with req/busy/done handshake
// Optional macro CC_DECODER_STROBE_G0PROTECT_EN write-protects index 0 (skips the strobe, still pulses done).
module cc_decoder_strobe #(
   parameter int DATAWIDTH_DECODER_SELECTION = 4,
   parameter int DATAWIDTH_DECODER_OUT       = 16,
   parameter int DECODER_VALID_COUNT         = 14,
   parameter int STROBE_CYCLES               = 1
) (
   input  logic                                   CC_DECODER_STROBE_CLOCK_50,
   input  logic                                   CC_DECODER_STROBE_RESET_InLow,
   input  logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_DECODER_STROBE_Selection_InBUS,
   input  logic                                   CC_DECODER_STROBE_Request_In,
   output logic [DATAWIDTH_DECODER_OUT-1:0]       CC_DECODER_STROBE_Selection_OutBUS,
   output logic                                   CC_DECODER_STROBE_Busy_Out,
   output logic                                   CC_DECODER_STROBE_Done_Out,
   output logic                                   CC_DECODER_STROBE_Error_Out
);

`ifdef CC_DECODER_STROBE_G0PROTECT_EN
   localparam bit G0_PROTECT = 1'b1;
`else
   localparam bit G0_PROTECT = 1'b0;
`endif

   localparam int unsigned VALID_LIMIT = DECODER_VALID_COUNT;
   localparam logic [3:0]  CNT_LOAD    = 4'(STROBE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, STROBE, DONE} state_t;

   state_t                                 state, state_n;
   logic [3:0]                             cnt, cnt_n;
   logic [DATAWIDTH_DECODER_SELECTION-1:0] idx, idx_n;
   logic [DATAWIDTH_DECODER_OUT-1:0]       strobe_r, strobe_n;
   logic                                   busy_r, busy_n;
   logic                                   done_r, done_n;
   logic                                   err_r, err_n;
   logic                                   sel_valid;

   assign sel_valid = 32'(CC_DECODER_STROBE_Selection_InBUS) < VALID_LIMIT;

   always_ff @(posedge CC_DECODER_STROBE_CLOCK_50) begin
      if (!CC_DECODER_STROBE_RESET_InLow) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         strobe_r <= '1;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         strobe_r <= strobe_n;
         busy_r   <= busy_n;
         done_r   <= done_n;
         err_r    <= err_n;
      end
   end

   // Outputs are computed for the next state so they can be registered with it.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      strobe_n = '1;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (CC_DECODER_STROBE_Request_In) begin
               if (!sel_valid) begin
                  err_n = 1'b1;
               end else if (G0_PROTECT && CC_DECODER_STROBE_Selection_InBUS == '0) begin
                  state_n = DONE;
                  busy_n  = 1'b1;
                  done_n  = 1'b1;
               end else begin
                  state_n  = STROBE;
                  idx_n    = CC_DECODER_STROBE_Selection_InBUS;
                  cnt_n    = CNT_LOAD;
                  busy_n   = 1'b1;
                  strobe_n[CC_DECODER_STROBE_Selection_InBUS] = 1'b0;
               end
            end
         end
         STROBE: begin
            busy_n = 1'b1;
            if (cnt == '0) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               cnt_n       = cnt - 4'd1;
               strobe_n[idx] = 1'b0;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign CC_DECODER_STROBE_Selection_OutBUS = strobe_r;
   assign CC_DECODER_STROBE_Busy_Out         = busy_r;
   assign CC_DECODER_STROBE_Done_Out         = done_r;
   assign CC_DECODER_STROBE_Error_Out        = err_r;

endmodule

// File: tb/tb_cc_decoder_strobe.sv
// tb/tb_cc_decoder_strobe.sv - self-checking bench for cc_decoder_strobe (STROBE_CYCLES 1 and 3 side by side)
// Reference model schedules each accepted request's output window into per-cycle expectation tables.
module tb_cc_decoder_strobe;

`ifdef CC_DECODER_STROBE_G0PROTECT_EN
   localparam bit G0 = 1'b1;
`else
   localparam bit G0 = 1'b0;
`endif

   localparam int N = 1024;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [3:0]  sel = '0;
   logic        req = 1'b0;
   logic [15:0] bus0, bus1;
   logic        busy0, busy1, done0, done1, err0, err1;

   int          tests = 0;
   int          fails = 0;
   int          edge_n = 0;
   int          sc [2] = '{1, 3};
   int          free_edge [2] = '{0, 0};

   logic [15:0] exp_bus  [2][N];
   logic        exp_busy [2][N];
   logic        exp_done [2][N];
   logic        exp_err  [2][N];

   always #5 clk = ~clk;

   cc_decoder_strobe #(.STROBE_CYCLES(1)) u_d1 (
      .CC_DECODER_STROBE_CLOCK_50        (clk),
      .CC_DECODER_STROBE_RESET_InLow     (rstn),
      .CC_DECODER_STROBE_Selection_InBUS (sel),
      .CC_DECODER_STROBE_Request_In      (req),
      .CC_DECODER_STROBE_Selection_OutBUS(bus0),
      .CC_DECODER_STROBE_Busy_Out        (busy0),
      .CC_DECODER_STROBE_Done_Out        (done0),
      .CC_DECODER_STROBE_Error_Out       (err0)
   );

   cc_decoder_strobe #(.STROBE_CYCLES(3)) u_d3 (
      .CC_DECODER_STROBE_CLOCK_50        (clk),
      .CC_DECODER_STROBE_RESET_InLow     (rstn),
      .CC_DECODER_STROBE_Selection_InBUS (sel),
      .CC_DECODER_STROBE_Request_In      (req),
      .CC_DECODER_STROBE_Selection_OutBUS(bus1),
      .CC_DECODER_STROBE_Busy_Out        (busy1),
      .CC_DECODER_STROBE_Done_Out        (done1),
      .CC_DECODER_STROBE_Error_Out       (err1)
   );

   task automatic clear_from(input int d, input int c0);
      for (int c = c0; c < N; c++) begin
         exp_bus[d][c]  = 16'hFFFF;
         exp_busy[d][c] = 1'b0;
         exp_done[d][c] = 1'b0;
         exp_err[d][c]  = 1'b0;
      end
   endtask

   // A request sampled at edge e owns cycles e+1 .. e+SC+1; the next one may start at edge e+SC+2.
   task automatic model_edge(input int d, input int e, input logic [3:0] s, input logic r, input logic rn);
      if (!rn) begin
         clear_from(d, e + 1);
         free_edge[d] = e + 1;
      end else if (r && e >= free_edge[d]) begin
         if (int'(s) >= 14) begin
            exp_err[d][e+1] = 1'b1;
         end else if (G0 && s == 4'd0) begin
            exp_busy[d][e+1] = 1'b1;
            exp_done[d][e+1] = 1'b1;
            free_edge[d] = e + 2;
         end else begin
            for (int c = e + 1; c <= e + sc[d]; c++) begin
               exp_bus[d][c]  = ~(16'd1 << s);
               exp_busy[d][c] = 1'b1;
            end
            exp_busy[d][e+sc[d]+1] = 1'b1;
            exp_done[d][e+sc[d]+1] = 1'b1;
            free_edge[d] = e + sc[d] + 2;
         end
      end
   endtask

   task automatic check_cycle(input int c);
      logic [15:0] b;
      logic        bz, dn, er;
      for (int d = 0; d < 2; d++) begin
         b  = (d == 0) ? bus0  : bus1;
         bz = (d == 0) ? busy0 : busy1;
         dn = (d == 0) ? done0 : done1;
         er = (d == 0) ? err0  : err1;
         tests += 4;
         assert (b === exp_bus[d][c]) else begin
            fails++;
            $error("FAIL bus dut%0d cyc%0d: got %h want %h", d, c, b, exp_bus[d][c]);
         end
         assert (bz === exp_busy[d][c]) else begin
            fails++;
            $error("FAIL busy dut%0d cyc%0d: got %b want %b", d, c, bz, exp_busy[d][c]);
         end
         assert (dn === exp_done[d][c]) else begin
            fails++;
            $error("FAIL done dut%0d cyc%0d: got %b want %b", d, c, dn, exp_done[d][c]);
         end
         assert (er === exp_err[d][c]) else begin
            fails++;
            $error("FAIL error dut%0d cyc%0d: got %b want %b", d, c, er, exp_err[d][c]);
         end
      end
   endtask

   task automatic step(input logic [3:0] s, input logic r, input logic rn);
      sel  = s;
      req  = r;
      rstn = rn;
      for (int d = 0; d < 2; d++) model_edge(d, edge_n, s, r, rn);
      @(posedge clk);
      #1;
      edge_n++;
      check_cycle(edge_n);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'd0, 1'b0, 1'b1);
   endtask

   initial begin
      clear_from(0, 0);
      clear_from(1, 0);

      step(4'd0, 1'b1, 1'b0);
      step(4'd9, 1'b1, 1'b0);

      // sel=3 single write
      step(4'd3, 1'b1, 1'b1);
      tests++;
      assert (bus0 === 16'hFFF7) else begin
         fails++;
         $error("FAIL first_strobe: got %h want %h", bus0, 16'hFFF7);
      end
      idle(6);

      // sel=13, IR
      step(4'd13, 1'b1, 1'b1);
      tests++;
      assert (bus1 === 16'hDFFF) else begin
         fails++;
         $error("FAIL ir_strobe: got %h want %h", bus1, 16'hDFFF);
      end
      idle(6);

      // out-of-range indices
      step(4'd14, 1'b1, 1'b1);
      step(4'd15, 1'b1, 1'b1);
      idle(2);

      // request held high, index changed mid-strobe
      step(4'd2, 1'b1, 1'b1);
      step(4'd2, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(4'd5, 1'b1, 1'b1);
      idle(6);

      // reset during a strobe
      step(4'd13, 1'b1, 1'b1);
      step(4'd0, 1'b0, 1'b1);
      step(4'd0, 1'b0, 1'b0);
      idle(5);

      // index 0 (g0)
      step(4'd0, 1'b1, 1'b1);
      tests++;
      assert (bus0 === (G0 ? 16'hFFFF : 16'hFFFE)) else begin
         fails++;
         $error("FAIL g0_strobe: got %h want %h", bus0, (G0 ? 16'hFFFF : 16'hFFFE));
      end
      idle(5);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(4'($urandom_range(0, 15)), ($urandom % 3) != 0, ($urandom % 40) != 0);
      end
      idle(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cc_decoder_strobe.md
Name: cc_decoder_strobe

Overview:
- Parametrised, registered successor to the combinational register-select decoder.
- Converts a register index plus request into a timed active-low one-hot write strobe for the register file (g0-g7, PC, Temp0-3, IR).
- Uses a req/busy/done handshake and flags out-of-range indices.
- Sits between the control unit and the register bank write enables.

Parameters:
- DATAWIDTH_DECODER_SELECTION, 4: index width.
- DATAWIDTH_DECODER_OUT, 16: strobe bus width; must equal 2**DATAWIDTH_DECODER_SELECTION.
- DECODER_VALID_COUNT, 14: indices 0..DECODER_VALID_COUNT-1 are valid; the rest are errors.
- STROBE_CYCLES, 1: active-low strobe width in clocks; legal range 1..15.

Ports:
- CC_DECODER_STROBE_CLOCK_50  in  1  system clock, rising edge.
- CC_DECODER_STROBE_RESET_InLow  in  1  synchronous, active-low reset.
- CC_DECODER_STROBE_Selection_InBUS  in  DATAWIDTH_DECODER_SELECTION  register index, sampled with request.
- CC_DECODER_STROBE_Request_In  in  1  write request, level-sampled in IDLE only.
- CC_DECODER_STROBE_Selection_OutBUS  out  DATAWIDTH_DECODER_OUT  registered active-low one-hot strobe.
- CC_DECODER_STROBE_Busy_Out  out  1  high while a write is in progress (STROBE or DONE).
- CC_DECODER_STROBE_Done_Out  out  1  one-cycle pulse at write completion.
- CC_DECODER_STROBE_Error_Out  out  1  one-cycle pulse on an out-of-range index.

Behaviour:
- One clock. Reset is synchronous and active-low; all state changes happen on the rising edge of CC_DECODER_STROBE_CLOCK_50.
- Reset (RESET_InLow=0 at an edge) forces:
  - state IDLE, strobe counter 0, latched index 0;
  - Selection_OutBUS all ones;
  - Busy_Out, Done_Out, Error_Out all 0.
  - Reset overrides all other inputs, including mid-strobe: the strobe deasserts at that edge and no Done pulse is issued.
- All outputs are registered. No combinational path from input to output.
- FSM states: IDLE, STROBE, DONE.
- IDLE:
  - Outputs all ones; Busy=0.
  - Request_In=1 at edge k with index < DECODER_VALID_COUNT: latch index, load counter with STROBE_CYCLES-1, go to STROBE. Selection_OutBUS bit[index]=0, all other bits 1, from cycle k+1.
  - Request_In=1 with index >= DECODER_VALID_COUNT: stay IDLE, Error_Out=1 for cycle k+1 only, strobe stays all ones.
  - Request_In=0: stay IDLE.
- STROBE:
  - Busy=1; strobe held from the latched index, so input changes are ignored.
  - Counter decrements each cycle. At counter 0, go to DONE.
  - The strobe is low for exactly STROBE_CYCLES cycles (k+1 .. k+STROBE_CYCLES).
- DONE:
  - Strobe all ones, Busy=1, Done_Out=1 for cycle k+STROBE_CYCLES+1; return to IDLE.
- Requests in STROBE or DONE are ignored, not queued.
- The earliest next acceptance is at edge k+STROBE_CYCLES+2, giving one write per STROBE_CYCLES+2 clocks.
- Never more than one strobe bit is low. The strobe bus is all ones outside STROBE.
- Error_Out and Done_Out are never high in the same cycle.
- Defaults reproduce the legacy map: index 8=PC, 9-12=Temp0-3, 13=IR; 14 and 15 are errors.

Optional Feature:
- Macro: CC_DECODER_STROBE_G0PROTECT_EN.
- Defined: index 0 (g0, hardwired zero) is write-protected.
  - A request for index 0 in IDLE skips STROBE and goes directly to DONE.
  - Done_Out pulses at k+1 with Busy=1 that cycle; no strobe bit goes low and no error is flagged.
- Undefined: index 0 is strobed like any other valid index.

Test Plan:
- Defaults; sel=3, Request=1 at edge 0, then 0 → OutBUS=16'hFFF7 in cycle 1; Done=1 and OutBUS=16'hFFFF in cycle 2; Busy=1 in cycles 1-2, 0 in cycle 3.
- STROBE_CYCLES=3; sel=13 → OutBUS=16'hDFFF in cycles 1-3; Done in cycle 4; next request accepted at edge 5.
- Request with sel=14, then sel=15 → Error=1 for one cycle each; OutBUS=16'hFFFF; Busy=0; Done=0.
- Request held high continuously with sel=2, then changed to 5 during STROBE → strobe stays 16'hFFFB; second write uses index 5 only after returning to IDLE.
- STROBE_CYCLES=3; RESET_InLow=0 at cycle 2 of a strobe → OutBUS=16'hFFFF, Busy=0, no Done pulse, state IDLE.
- Macro defined, sel=0 → no low strobe bit, Done at cycle 1. Macro undefined, sel=0 → OutBUS=16'hFFFE in cycle 1.
